// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register placed directly after the register file.
// It resolves both source operands, extends the 16-bit immediate, detects RAW
// hazards, inserts bubbles and stalls fetch/decode. It also honours a downstream
// hold and a branch flush.
//
// Optional build macro: OPERAND_FWD_EN
//   defined   - EX/MEM bypass network; only a load-use costs a bubble (exactly one)
//   undefined - operands always come from the register file; any RAW against a
//               live EX or MEM writer stalls until that writer has retired
//
// Ports:
//   clock, reset                      pipeline clock, asynchronous active-high reset
//   in_valid                          decode slot holds a real instruction
//   in_rs, in_rt, in_dst              source A/B and destination register addresses
//   in_rf_data_1, in_rf_data_2        register-file read data for rs / rt
//   in_imm16, in_sign_ext             raw immediate and extension mode
//   in_reg_write, in_mem_read         decoded control bits
//   ex_result                         ALU result of the instruction held in this stage
//   mem_reg_write, mem_dst, mem_result MEM-stage writer info (load data for loads)
//   ex_hold                           downstream stall, freeze all outputs
//   flush                             squash the decode slot
//   stall_id                          freeze PC and IF/ID (combinational)
//   out_*                             registered control, destination, operands, immediate
module id_ex_operand_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_rs,
    input  logic [ADDR_WIDTH-1:0] in_rt,
    input  logic [ADDR_WIDTH-1:0] in_dst,
    input  logic [DATA_WIDTH-1:0] in_rf_data_1,
    input  logic [DATA_WIDTH-1:0] in_rf_data_2,
    input  logic [15:0]           in_imm16,
    input  logic                  in_sign_ext,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic                  mem_reg_write,
    input  logic [ADDR_WIDTH-1:0] mem_dst,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  ex_hold,
    input  logic                  flush,
    output logic                  stall_id,
    output logic                  out_valid,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic [ADDR_WIDTH-1:0] out_dst,
    output logic [DATA_WIDTH-1:0] out_op_a,
    output logic [DATA_WIDTH-1:0] out_op_b,
    output logic [DATA_WIDTH-1:0] out_imm32
);

    localparam int unsigned IMM_WIDTH = 16;

    logic                  ex_live;
    logic                  mem_live;
    logic                  hazard;
    logic [DATA_WIDTH-1:0] op_a_next;
    logic [DATA_WIDTH-1:0] op_b_next;
    logic [DATA_WIDTH-1:0] imm32_next;

    // Register 0 is never a real destination, so writers to it are ignored.
    assign ex_live  = out_valid && out_reg_write && (out_dst != '0);
    assign mem_live = mem_reg_write && (mem_dst != '0);

`ifdef OPERAND_FWD_EN
    // Only a load still in EX cannot be bypassed; it is caught one cycle later via MEM.
    assign hazard = in_valid && out_valid && out_mem_read && (out_dst != '0) &&
                    ((out_dst == in_rs) || (out_dst == in_rt));

    // Operand A: zero register, then youngest live writer, then register file.
    always_comb begin
        op_a_next = in_rf_data_1;
        if (in_rs == '0)
            op_a_next = '0;
        else if (ex_live && !out_mem_read && (in_rs == out_dst))
            op_a_next = ex_result;
        else if (mem_live && (in_rs == mem_dst))
            op_a_next = mem_result;
    end

    // Operand B: same priority as operand A.
    always_comb begin
        op_b_next = in_rf_data_2;
        if (in_rt == '0)
            op_b_next = '0;
        else if (ex_live && !out_mem_read && (in_rt == out_dst))
            op_b_next = ex_result;
        else if (mem_live && (in_rt == mem_dst))
            op_b_next = mem_result;
    end
`else
    logic unused_bypass_data;

    // Bypass data is not consumed in this build.
    assign unused_bypass_data = ^{ex_result, mem_result};

    // Any pending writer of a source register stalls until it reaches WB.
    assign hazard = in_valid &&
                    (((in_rs != '0) && ((ex_live && (in_rs == out_dst)) ||
                                        (mem_live && (in_rs == mem_dst)))) ||
                     ((in_rt != '0) && ((ex_live && (in_rt == out_dst)) ||
                                        (mem_live && (in_rt == mem_dst)))));

    // Operands straight from the register file; register 0 always reads zero.
    always_comb begin
        op_a_next = in_rf_data_1;
        op_b_next = in_rf_data_2;
        if (in_rs == '0)
            op_a_next = '0;
        if (in_rt == '0)
            op_b_next = '0;
    end
`endif

    // Immediate extension.
    always_comb begin
        imm32_next = DATA_WIDTH'(in_imm16);
        if (in_sign_ext)
            imm32_next = {{(DATA_WIDTH - IMM_WIDTH){in_imm16[IMM_WIDTH-1]}}, in_imm16};
    end

    // A flush makes the hazard moot because the dependent instruction is squashed.
    assign stall_id = ex_hold || (hazard && !flush);

    // Pipeline register: flush > hold > bubble > capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_dst       <= '0;
            out_op_a      <= '0;
            out_op_b      <= '0;
            out_imm32     <= '0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (ex_hold) begin
            out_valid     <= out_valid;
        end else if (hazard) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else begin
            out_valid     <= in_valid;
            out_reg_write <= in_valid && in_reg_write;
            out_mem_read  <= in_valid && in_mem_read;
            out_dst       <= in_dst;
            out_op_a      <= op_a_next;
            out_op_b      <= op_b_next;
            out_imm32     <= imm32_next;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a capture table plus hand-written
// sequences for reset, RAW hazards, bypass priority, hold and flush.
module tb_id_ex_operand_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [AW-1:0] in_rs, in_rt, in_dst;
    logic [DW-1:0] in_rf_data_1, in_rf_data_2;
    logic [15:0]   in_imm16;
    logic          in_sign_ext, in_reg_write, in_mem_read;
    logic [DW-1:0] ex_result;
    logic          mem_reg_write;
    logic [AW-1:0] mem_dst;
    logic [DW-1:0] mem_result;
    logic          ex_hold, flush;
    logic          stall_id;
    logic          out_valid, out_reg_write, out_mem_read;
    logic [AW-1:0] out_dst;
    logic [DW-1:0] out_op_a, out_op_b, out_imm32;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    id_ex_operand_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst),
        .in_rf_data_1(in_rf_data_1), .in_rf_data_2(in_rf_data_2),
        .in_imm16(in_imm16), .in_sign_ext(in_sign_ext),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .ex_result(ex_result),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
        .ex_hold(ex_hold), .flush(flush), .stall_id(stall_id),
        .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_dst(out_dst), .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm32(out_imm32)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] rs, rt, dst;
        logic [DW-1:0] rf1, rf2;
        logic [15:0]   imm;
        logic          sext, rw, mr;
        logic          e_v, e_rw, e_mr;
        logic [AW-1:0] e_dst;
        logic [DW-1:0] e_a, e_b, e_imm;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs = '0; in_rt = '0; in_dst = '0;
        in_rf_data_1 = '0; in_rf_data_2 = '0; in_imm16 = '0; in_sign_ext = 0;
        in_reg_write = 0; in_mem_read = 0; ex_result = '0;
        mem_reg_write = 0; mem_dst = '0; mem_result = '0;
        ex_hold = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] dst, input logic [DW-1:0] rf1,
                         input logic [DW-1:0] rf2, input logic rw, input logic mr);
        in_valid = v; in_rs = rs; in_rt = rt; in_dst = dst;
        in_rf_data_1 = rf1; in_rf_data_2 = rf2; in_reg_write = rw; in_mem_read = mr;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, DW'(out_valid), '0);
        chk({nm, "_rw"}, DW'(out_reg_write), '0);
        chk({nm, "_mr"}, DW'(out_mem_read), '0);
        chk({nm, "_dst"}, DW'(out_dst), '0);
        chk({nm, "_op_a"}, out_op_a, '0);
        chk({nm, "_op_b"}, out_op_b, '0);
        chk({nm, "_imm"}, out_imm32, '0);
        chk({nm, "_stall"}, DW'(stall_id), '0);
    endtask

    // Producer writes $8 (load or ALU op); consumer uses rt = 8.
    task automatic raw_seq(input logic is_load, input string nm);
        logic [DW-1:0] r;
        int nb;
        r = is_load ? DW'(32'hCAFE) : DW'(32'h1234);
`ifdef OPERAND_FWD_EN
        nb = is_load ? 1 : 0;
`else
        nb = 2;
`endif
        @(negedge clock);
        idle_inputs();
        drive(1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 1, is_load);
        step();
        chk({nm, "_prod_valid"}, DW'(out_valid), 1);
        chk({nm, "_prod_mr"}, DW'(out_mem_read), DW'(is_load));
        for (int k = 0; k <= nb; k++) begin
            @(negedge clock);
            drive(1, 5'd9, 5'd8, 5'd10, 32'h99, 32'hDEAD, 1, 0);
            ex_result = (k == 0) ? DW'(32'h1234) : DW'(32'h0BAD);
            mem_reg_write = (k == 1); mem_dst = (k == 1) ? 5'd8 : 5'd0;
            mem_result = (k == 1) ? r : DW'(32'h0BAD);
            if (k >= 2) in_rf_data_2 = r;
            #1;
            chk($sformatf("%s_stall_k%0d", nm, k), DW'(stall_id), DW'(k < nb));
            step();
            chk($sformatf("%s_valid_k%0d", nm, k), DW'(out_valid), DW'(k >= nb));
        end
        chk({nm, "_dst"}, DW'(out_dst), 10);
        chk({nm, "_op_a"}, out_op_a, 32'h99);
        chk({nm, "_op_b"}, out_op_b, r);
        @(negedge clock);
        idle_inputs();
        step();
    endtask

    initial begin
        // v rs rt dst rf1 rf2 imm sext rw mr -> e_v e_rw e_mr e_dst e_a e_b e_imm
        vecs[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 16'h8001, 1'b1, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'd3, 32'h1111, 32'h2222, 32'hFFFF8001};
        vecs[1] = '{1'b1, 5'd4, 5'd0, 5'd31, 32'h000A, 32'hFFFF, 16'h8001, 1'b0, 1'b1, 1'b0,
                    1'b1, 1'b1, 1'b0, 5'd31, 32'h000A, 32'h0, 32'h00008001};
        vecs[2] = '{1'b1, 5'd0, 5'd6, 5'd30, 32'hFFFF, 32'h0066, 16'h7FFF, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 5'd30, 32'h0, 32'h0066, 32'h00007FFF};
        vecs[3] = '{1'b0, 5'd7, 5'd8, 5'd9, 32'h0077, 32'h0088, 16'hFFFF, 1'b1, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 5'd9, 32'h0077, 32'h0088, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 5'd30, 5'd30, 5'd1, 32'h3030, 32'h3131, 16'h0000, 1'b1, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'd1, 32'h3030, 32'h3131, 32'h0};

        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        reset = 0;

        // Capture table: no vector depends on a live writer.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].dst, vecs[i].rf1, vecs[i].rf2,
                  vecs[i].rw, vecs[i].mr);
            in_imm16 = vecs[i].imm; in_sign_ext = vecs[i].sext;
            #1;
            chk($sformatf("v%0d_stall", i), DW'(stall_id), '0);
            step();
            chk($sformatf("v%0d_valid", i), DW'(out_valid), DW'(vecs[i].e_v));
            chk($sformatf("v%0d_rw", i), DW'(out_reg_write), DW'(vecs[i].e_rw));
            chk($sformatf("v%0d_mr", i), DW'(out_mem_read), DW'(vecs[i].e_mr));
            chk($sformatf("v%0d_dst", i), DW'(out_dst), DW'(vecs[i].e_dst));
            chk($sformatf("v%0d_op_a", i), out_op_a, vecs[i].e_a);
            chk($sformatf("v%0d_op_b", i), out_op_b, vecs[i].e_b);
            chk($sformatf("v%0d_imm", i), out_imm32, vecs[i].e_imm);
        end

        // Asynchronous reset while a valid instruction is held.
        @(negedge clock);
        idle_inputs();
        #2;
        reset = 1;
        #1;
        chk_all_zero("midreset");
        @(negedge clock);
        reset = 0;

        raw_seq(1'b0, "raw_alu");
        raw_seq(1'b1, "raw_load");

`ifdef OPERAND_FWD_EN
        // Bypass priority: EX beats MEM, MEM beats register file.
        @(negedge clock);
        drive(1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1, 0);
        step();
        @(negedge clock);
        drive(1, 5'd5, 5'd0, 5'd6, 32'hFFFF, 32'hFFFF, 1, 0);
        ex_result = 32'h11; mem_reg_write = 1; mem_dst = 5'd5; mem_result = 32'h22;
        #1;
        chk("byp_ex_stall", DW'(stall_id), '0);
        step();
        chk("byp_ex_op_a", out_op_a, 32'h11);
        chk("byp_ex_op_b", out_op_b, '0);
        @(negedge clock);
        drive(1, 5'd5, 5'd0, 5'd7, 32'hFFFF, 32'hFFFF, 1, 0);
        ex_result = 32'h33;
        step();
        chk("byp_mem_op_a", out_op_a, 32'h22);
        @(negedge clock);
        idle_inputs();
        step();
`endif

        // Hold for three cycles, then flush together with hold.
        @(negedge clock);
        idle_inputs();
        drive(1, 5'd1, 5'd2, 5'd12, 32'hAAAA, 32'hBBBB, 1, 0);
        step();
        chk("hold_cap_op_a", out_op_a, 32'hAAAA);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(1, 5'd1, 5'd2, 5'd13, 32'h5555, 32'h6666, 0, 1);
            ex_hold = 1;
            #1;
            chk($sformatf("hold_stall_%0d", k), DW'(stall_id), 1);
            step();
            chk($sformatf("hold_valid_%0d", k), DW'(out_valid), 1);
            chk($sformatf("hold_rw_%0d", k), DW'(out_reg_write), 1);
            chk($sformatf("hold_dst_%0d", k), DW'(out_dst), 12);
            chk($sformatf("hold_op_a_%0d", k), out_op_a, 32'hAAAA);
            chk($sformatf("hold_op_b_%0d", k), out_op_b, 32'hBBBB);
        end
        @(negedge clock);
        flush = 1;
        #1;
        chk("flush_stall", DW'(stall_id), 1);
        step();
        chk("flush_valid", DW'(out_valid), '0);
        chk("flush_rw", DW'(out_reg_write), '0);
        chk("flush_mr", DW'(out_mem_read), '0);
        @(negedge clock);
        idle_inputs();
        #1;
        chk("after_flush_stall", DW'(stall_id), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
Decode-to-execute pipeline register of the MIPS core, directly downstream of the register file. Captures the two register-file read operands, selects bypassed values from the EX and MEM stages, and sign- or zero-extends the 16-bit immediate. Detects load-use hazards, inserts bubbles, and raises a stall to the fetch/decode stages. Honours downstream hold and branch flush.

Parameters:
DATA_WIDTH, 32, operand/result width
ADDR_WIDTH, 5, register address width (32 registers)

Ports:
clock  in  1  pipeline clock; all state updates on posedge
reset  in  1  asynchronous, active-high
in_valid  in  1  decode slot holds a real instruction
in_rs  in  ADDR_WIDTH  source register A address (also drives register-file read port 1)
in_rt  in  ADDR_WIDTH  source register B address (also drives register-file read port 2)
in_dst  in  ADDR_WIDTH  destination register of decoded instruction
in_rf_data_1  in  DATA_WIDTH  register-file read data, port 1 (valid at posedge)
in_rf_data_2  in  DATA_WIDTH  register-file read data, port 2
in_imm16  in  16  raw immediate
in_sign_ext  in  1  1 = sign-extend, 0 = zero-extend
in_reg_write  in  1  decoded instruction writes a register
in_mem_read  in  1  decoded instruction is a load
ex_result  in  DATA_WIDTH  ALU result of the instruction currently held in this stage's outputs
mem_reg_write, mem_dst, mem_result  in  1/ADDR_WIDTH/DATA_WIDTH  MEM-stage writer info (mem_result is load data for loads)
ex_hold  in  1  downstream stall; freeze all outputs
flush  in  1  squash the decode slot
stall_id  out  1  freeze PC and IF/ID (combinational)
out_valid, out_reg_write, out_mem_read  out  1  registered control
out_dst  out  ADDR_WIDTH  registered destination
out_op_a, out_op_b  out  DATA_WIDTH  registered resolved operands
out_imm32  out  DATA_WIDTH  registered extended immediate

Behaviour:
- Reset (asynchronous): every registered output goes to 0; stall_id follows its combinational equation using the cleared state.
- Live writer in EX: out_valid && out_reg_write && out_dst != 0.
- Live writer in MEM: mem_reg_write && mem_dst != 0.
- Operand resolution, per source (rs -> op_a, rt -> op_b), highest priority first:
  - address 0 -> 0
  - match with the live EX writer (not a load) -> ex_result
  - match with the live MEM writer -> mem_result
  - otherwise in_rf_data_x
- WB-stage writes need no bypass: the register file writes on posedge and reads on negedge.
- load_use = in_valid && out_valid && out_mem_read && out_dst != 0 && (out_dst == in_rs || out_dst == in_rt).
- stall_id = ex_hold || (load_use && !flush).
- Posedge update priority:
  1. flush: out_valid, out_reg_write and out_mem_read <= 0; data fields don't-care. Flush overrides ex_hold.
  2. ex_hold: all outputs keep their values.
  3. load_use: bubble; control bits <= 0. The instruction stays in decode and is re-evaluated next cycle, when the load is in MEM and is taken via mem_result. Result: exactly 1 bubble.
  4. otherwise: capture resolved operands, out_imm32 = ext(in_imm16), in_dst and the control bits gated by in_valid.
- Latency: 1 cycle from decode to outputs.
- When in_valid = 0, the control bits captured are 0.

Optional Feature:
OPERAND_FWD_EN
- Defined: bypass network as above; load-use costs 1 bubble.
- Undefined: operands always come from in_rf_data_x (address 0 still reads 0); ex_result and mem_result are ignored. Hazard becomes in_valid && source != 0 && source matches the live EX writer or the live MEM writer (any instruction type). Bubbles are inserted until the condition clears, so a back-to-back RAW costs 2 bubbles.

Test Plan:
- Reset mid-operation with out_valid = 1 -> all outputs 0 immediately; stall_id = 0 while ex_hold = 0.
- Bypass priority: rs = 5, EX writer dst 5 with ex_result = 0x11, MEM writer dst 5 with mem_result = 0x22 -> out_op_a = 0x11; MEM-only match -> 0x22; rs = 0 with rf data 0xFFFF -> 0.
- Load-use: lw $8 in stage, next instruction uses rt = 8 -> stall_id = 1 for 1 cycle, one bubble (out_valid = 0); then out_op_b = mem_result 0xCAFE.
- Hold versus flush: ex_hold = 1 for 3 cycles -> outputs stable and stall_id = 1; flush with ex_hold both set -> out_valid = 0 next edge.
- Immediates: in_imm16 = 0x8001 -> 0xFFFF8001 with sign-ext, 0x00008001 with zero-ext.
- Without OPERAND_FWD_EN: add $3 followed by sub using $3 -> 2 bubbles, operand taken from the register file.
